ysyx_22041412_clint_slave: RTL and testbench
============================================

YSYX_22041412_CLINT_SLAVE -- requirements
Module: ysyx_22041412_clint_slave

Interface
REQ-001 SHALL have parameter MTIMECMP_RST, default 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.
REQ-002 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  core request valid.
REQ-005 SHALL have port req_ready  output  1  slave accepts request.
REQ-006 SHALL have port req_wen  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  16  byte offset within CLINT window.
REQ-008 SHALL have port req_wdata  input  64  write data.
REQ-009 SHALL have port req_wstrb  input  8  byte-lane write enables.
REQ-010 SHALL have port rsp_valid  output  1  response valid.
REQ-011 SHALL have port rsp_ready  input  1  core accepts response.
REQ-012 SHALL have port rsp_rdata  output  64  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err  output  1  unmapped or misaligned access.
REQ-014 SHALL have port mtime_en  input  1  timer tick enable.
REQ-015 SHALL have port mtip  output  1  machine timer interrupt pending.
REQ-016 SHALL have port msip  output  1  machine software interrupt pending.
REQ-017 SHALL have port mtime_o  output  64  current mtime value.

Function
REQ-018 SHALL map MSIP at 0x0000, MTIMECMP at 0x4000, MTIME at 0xBFF8; all accesses SHALL be 8-byte aligned (req_addr[2:0]==0).
REQ-019 SHALL implement FSM IDLE/RESP: IDLE drives req_ready=1, rsp_valid=0; RESP drives req_ready=0, rsp_valid=1.
REQ-020 Handshake req_valid&req_ready in IDLE SHALL move to RESP on the same edge; response valid exactly 1 cycle after acceptance.
REQ-021 RESP SHALL hold rsp_rdata/rsp_err stable until rsp_valid&rsp_ready, then return to IDLE; no back-to-back acceptance in that cycle.
REQ-022 Writes SHALL commit on the acceptance edge, byte-merged per req_wstrb; wstrb=0 SHALL be a legal no-op write.
REQ-023 MSIP SHALL store only bit 0 (wstrb[0] lane); reads return {63'b0, msip}.
REQ-024 Reads SHALL sample register value before any same-edge update (read-old).
REQ-025 Unmapped or misaligned access SHALL set rsp_err=1, rsp_rdata=0, no state change.
REQ-026 mtime SHALL increment by 1 on each edge with mtime_en=1, wrapping 2^64-1 -> 0.
REQ-027 Write to MTIME on an edge with mtime_en=1 SHALL take the written value, no increment that edge.
REQ-028 mtip SHALL be registered: next mtip = (mtime >= mtimecmp), unsigned 64-bit, from current-cycle register values (1-cycle lag).
REQ-029 mtip SHALL clear the cycle after mtimecmp is written above mtime; no sticky behaviour.
REQ-030 msip output SHALL be the MSIP register bit directly.
REQ-031 mtime_o SHALL be the mtime register directly.

Reset
REQ-032 On rst low, asynchronously: FSM=IDLE, mtime=0, mtimecmp=MTIMECMP_RST, msip=0, mtip=0, rsp_rdata=0, rsp_err=0.
REQ-033 Reset during RESP SHALL drop the pending response; first edge after release SHALL be IDLE with req_ready=1.

Structure
REQ-034 Package ysyx_22041412_clint_pkg SHALL hold address offset constants (MSIP/MTIMECMP/MTIME) and the FSM state typedef.
REQ-035 One sub-module ysyx_22041412_clint_timer SHALL hold mtime counter, mtimecmp register, and registered mtip compare; bus decode/FSM remain top-level.

Verification
REQ-036 Reset release, read 0xBFF8 with mtime_en=0 -> rsp 1 cycle later, rdata=0, err=0; mtip=0.
REQ-037 Write MTIMECMP=5, mtime_en=1 steady -> mtip rises 1 cycle after mtime reaches 5; write MTIMECMP=100 -> mtip=0 next-but-one cycle.
REQ-038 Write MTIME=64'hFFFF_FFFF_FFFF_FFFE, mtime_en=1 -> mtime_o reads ...FFFF then 0 on successive cycles.
REQ-039 Write MSIP wdata=64'hFF, wstrb=8'h01 -> msip=1, read returns 1; wstrb=8'h00 write of 0 -> msip stays 1.
REQ-040 Read 0x0004 and 0x1000 -> rsp_err=1, rdata=0, no register changes; hold rsp_ready=0 for 3 cycles -> rsp_valid and data held, req_ready=0.
REQ-041 Assert rst mid-RESP -> rsp_valid drops immediately, mtimecmp=MTIMECMP_RST, req_ready=1 after release.

Source files
------------

// File: rtl/ysyx_22041412_clint_pkg.sv
// CLINT slave shared definitions: register offsets, FSM encoding, byte-merge helper.
package ysyx_22041412_clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  typedef logic [0:0] state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StResp = 1'b1;

  // Replace each byte of old_val whose strobe is set with the matching byte of wdata.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  wstrb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_22041412_clint_timer.sv
// CLINT timer: free-running mtime, mtimecmp register and registered compare (mtip).
module ysyx_22041412_clint_timer
  import ysyx_22041412_clint_pkg::*;
#(
  parameter logic [63:0] MtimecmpRst = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mtime_en_i,
  input  logic        mtime_we_i,
  input  logic        mtimecmp_we_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wstrb_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        mtip_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        mtip_q;

  // Next-state: a bus write to mtime overrides the tick for that edge.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (mtime_we_i) begin
      mtime_d = strb_merge(mtime_q, wdata_i, wstrb_i);
    end else if (mtime_en_i) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (mtimecmp_we_i) begin
      mtimecmp_d = strb_merge(mtimecmp_q, wdata_i, wstrb_i);
    end
  end

  // Timer state; mtip compares current register values, so it lags by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= MtimecmpRst;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end

  assign mtime_o    = mtime_q;
  assign mtimecmp_o = mtimecmp_q;
  assign mtip_o     = mtip_q;

endmodule

// File: rtl/ysyx_22041412_clint_slave.sv
// CLINT bus slave: one outstanding request, decode of MSIP/MTIMECMP/MTIME, registered response.
module ysyx_22041412_clint_slave #(
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        mtime_en,
  output logic        mtip,
  output logic        msip,
  output logic [63:0] mtime_o
);
  import ysyx_22041412_clint_pkg::*;

  state_t      state_q, state_d;
  logic        msip_q, msip_d;
  logic [63:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        accept, aligned, hit_msip, hit_cmp, hit_time, addr_err, wr;
  logic [63:0] rd_val, mtime_val, mtimecmp_val;

  assign accept   = req_valid && (state_q == StIdle);
  assign aligned  = (req_addr[2:0] == 3'b000);
  assign hit_msip = aligned && (req_addr == MSIP_OFF);
  assign hit_cmp  = aligned && (req_addr == MTIMECMP_OFF);
  assign hit_time = aligned && (req_addr == MTIME_OFF);
  assign addr_err = !(hit_msip || hit_cmp || hit_time);
  assign wr       = accept && req_wen && !addr_err;

  // Read mux sees pre-edge register values, giving read-old semantics.
  always_comb begin
    rd_val = 64'd0;
    if (hit_msip)      rd_val = {63'd0, msip_q};
    else if (hit_cmp)  rd_val = mtimecmp_val;
    else if (hit_time) rd_val = mtime_val;
  end

  // Next-state for FSM and MSIP bit.
  always_comb begin
    state_d = state_q;
    msip_d  = msip_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StResp;
      default: if (rsp_ready) state_d = StIdle;
    endcase
    if (wr && hit_msip && req_wstrb[0]) msip_d = req_wdata[0];
  end

  // FSM, MSIP and response registers; response captured only on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      msip_q      <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      msip_q  <= msip_d;
      if (accept) begin
        rsp_rdata_q <= (req_wen || addr_err) ? 64'd0 : rd_val;
        rsp_err_q   <= addr_err;
      end
    end
  end

  ysyx_22041412_clint_timer #(
    .MtimecmpRst(MTIMECMP_RST)
  ) u_timer (
    .clk_i        (clk),
    .rst_ni       (rst),
    .mtime_en_i   (mtime_en),
    .mtime_we_i   (wr && hit_time),
    .mtimecmp_we_i(wr && hit_cmp),
    .wdata_i      (req_wdata),
    .wstrb_i      (req_wstrb),
    .mtime_o      (mtime_val),
    .mtimecmp_o   (mtimecmp_val),
    .mtip_o       (mtip)
  );

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign msip      = msip_q;
  assign mtime_o   = mtime_val;

endmodule

// File: tb/tb_ysyx_22041412_clint_slave.sv
// Self-checking bench: cycle-level reference model plus response scoreboard.
module tb_ysyx_22041412_clint_slave;

  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0, rsp_ready = 1'b0, mtime_en = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [7:0]  req_wstrb = 8'd0;
  logic        req_ready, rsp_valid, rsp_err, mtip, msip;
  logic [63:0] rsp_rdata, mtime_o;

  ysyx_22041412_clint_slave #(
    .MTIMECMP_RST(CMP_RST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen  (req_wen),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .mtime_en (mtime_en),
    .mtip     (mtip),
    .msip     (msip),
    .mtime_o  (mtime_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference state of the CLINT as seen after each rising edge.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_mtip, m_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mtime = 64'd0;
    m_cmp   = CMP_RST;
    m_msip  = 1'b0;
    m_mtip  = 1'b0;
    m_busy  = 1'b0;
  endtask

  task automatic check_state();
    chk("req_ready", {63'd0, req_ready}, {63'd0, !m_busy});
    chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_busy});
    chk("mtime_o", mtime_o, m_mtime);
    chk("mtip", {63'd0, mtip}, {63'd0, m_mtip});
    chk("msip", {63'd0, msip}, {63'd0, m_msip});
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] w,
                                        input logic [7:0] s);
    logic [63:0] mask;
    mask = 64'd0;
    for (int i = 0; i < 8; i++) if (s[i]) mask = mask | (64'hFF << (8 * i));
    return (o & ~mask) | (w & mask);
  endfunction

  // Advance one clock using the currently driven inputs, then compare.
  task automatic tick();
    logic [63:0] nt, nc, rv;
    logic        nmsip, nbusy, err;
    nt    = mtime_en ? m_mtime + 64'd1 : m_mtime;
    nc    = m_cmp;
    nmsip = m_msip;
    nbusy = m_busy;
    if (!m_busy && req_valid) begin
      nbusy = 1'b1;
      err   = !(req_addr == 16'h0000 || req_addr == 16'h4000 || req_addr == 16'hBFF8);
      rv    = 64'd0;
      if (!err && !req_wen) begin
        if (req_addr == 16'h0000)      rv = {63'd0, m_msip};
        else if (req_addr == 16'h4000) rv = m_cmp;
        else                           rv = m_mtime;
      end
      if (!err && req_wen) begin
        if (req_addr == 16'h0000 && req_wstrb[0]) nmsip = req_wdata[0];
        if (req_addr == 16'h4000) nc = merge(m_cmp, req_wdata, req_wstrb);
        if (req_addr == 16'hBFF8) nt = merge(m_mtime, req_wdata, req_wstrb);
      end
      exp_q.push_back('{rdata: rv, err: err});
    end else if (m_busy && rsp_ready) begin
      nbusy = 1'b0;
    end
    @(posedge clk);
    #1;
    m_mtip  = (m_mtime >= m_cmp);
    m_mtime = nt;
    m_cmp   = nc;
    m_msip  = nmsip;
    m_busy  = nbusy;
    check_state();
  endtask

  // One full transaction starting from idle; response held unready for `hold` cycles.
  task automatic xfer(input logic wen, input logic [15:0] addr, input logic [63:0] wd,
                      input logic [7:0] ws, input int hold);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < hold; i++) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Monitor: every valid response cycle is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
      end else begin
        chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, exp_q[0].err});
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] addrs [7];
    addrs = '{16'h0000, 16'h4000, 16'hBFF8, 16'h0004, 16'h1000, 16'h4004, 16'hBFF0};
    model_reset();
    #12;
    check_state();
    rst = 1'b1;
    tick();

    // Read mtime with the timer halted.
    xfer(1'b0, 16'hBFF8, 64'd0, 8'h00, 0);

    // mtimecmp compare, then raise compare above mtime.
    mtime_en = 1'b1;
    xfer(1'b1, 16'h4000, 64'd5, 8'hFF, 0);
    for (int i = 0; i < 8; i++) tick();
    xfer(1'b1, 16'h4000, 64'd100, 8'hFF, 0);
    for (int i = 0; i < 3; i++) tick();

    // mtime wrap.
    xfer(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0);
    for (int i = 0; i < 3; i++) tick();
    xfer(1'b1, 16'h4000, 64'hFFFF_FFFF_0000_0000, 8'hF0, 1);

    // MSIP: only bit 0 lane counts, zero strobe is a no-op.
    xfer(1'b1, 16'h0000, 64'hFF, 8'h01, 0);
    xfer(1'b0, 16'h0000, 64'd0, 8'h00, 0);
    xfer(1'b1, 16'h0000, 64'h0, 8'h00, 0);
    xfer(1'b0, 16'h0000, 64'd0, 8'h00, 0);

    // Error accesses with back-pressure.
    xfer(1'b0, 16'h0004, 64'd0, 8'h00, 3);
    xfer(1'b0, 16'h1000, 64'd0, 8'h00, 3);
    xfer(1'b1, 16'h4004, 64'd7, 8'hFF, 1);

    // Reset while a response is pending.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 16'h4000;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    exp_q.delete();
    model_reset();
    #2;
    rst = 1'b1;
    tick();
    xfer(1'b0, 16'h4000, 64'd0, 8'h00, 0);

    // Randomized traffic, including requests asserted while busy.
    for (int n = 0; n < 400; n++) begin
      mtime_en  = ($urandom_range(0, 3) != 0);
      req_valid = ($urandom_range(0, 2) == 0);
      req_wen   = $urandom_range(0, 1);
      req_addr  = addrs[$urandom_range(0, 6)];
      req_wdata = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 600))
                                             : {$urandom, $urandom};
      req_wstrb = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      rsp_ready = ($urandom_range(0, 1) != 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tick();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
